// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS core: load-use and branch-operand stalls,
// taken-branch flush and halt drain. Define HAZARD_CTRL_STATS_EN to add the StallCycles counter.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic [4:0]  RegRS_IFID,
    input  logic [4:0]  RegRT_IFID,
    input  logic        UsesRT_IFID,
    input  logic        Branch_IFID,
    input  logic        Halt_IFID,
    input  logic        Taken_ID,
    input  logic        MemRead_IDEX,
    input  logic        RegWrite_IDEX,
    input  logic [4:0]  RegDst_IDEX,
    input  logic        MemRead_EXMEM,
    input  logic [4:0]  RegDst_EXMEM,
`ifdef HAZARD_CTRL_STATS_EN
    output logic [31:0] StallCycles,
`endif
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXBubble,
    output logic        IFIDFlush,
    output logic        Halted
);

    typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               match_ex, match_mem;
    logic               load_use, br_alu, br_mem, hazard, need2;
    logic               pc_raw, ifid_raw, bub_raw, flush_raw;
    logic               active;

    assign match_ex  = (RegDst_IDEX != 5'd0) &&
                       ((RegDst_IDEX == RegRS_IFID) || (UsesRT_IFID && (RegDst_IDEX == RegRT_IFID)));
    assign match_mem = (RegDst_EXMEM != 5'd0) &&
                       ((RegDst_EXMEM == RegRS_IFID) || (UsesRT_IFID && (RegDst_EXMEM == RegRT_IFID)));

    assign load_use = MemRead_IDEX && match_ex;
    assign br_alu   = Branch_IFID && RegWrite_IDEX && !MemRead_IDEX && match_ex;
    assign br_mem   = Branch_IFID && MemRead_EXMEM && match_mem;
    assign hazard   = load_use || br_alu || br_mem;
    // A branch behind a load needs the value out of MEM, so one extra stall cycle.
    assign need2    = load_use && Branch_IFID;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_raw    = 1'b0;
        ifid_raw  = 1'b0;
        bub_raw   = 1'b0;
        flush_raw = 1'b0;
        case (state)
            RUN: begin
                if (hazard) begin
                    bub_raw = 1'b1;
                    if (need2) begin
                        state_nxt = STALL;
                        cnt_nxt   = CNT_W'(1);
                    end
                end else if (Halt_IFID) begin
                    bub_raw   = 1'b1;
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
                end else begin
                    pc_raw    = 1'b1;
                    ifid_raw  = 1'b1;
                    flush_raw = Taken_ID;
                end
            end
            STALL: begin
                bub_raw = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = RUN;
            end
            DRAIN: begin
                bub_raw = 1'b1;
                if (cnt == '0) state_nxt = HALTED;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else if (i_enable) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Frozen or in reset: the pipeline must see no enables, bubbles or flushes.
    assign active     = i_enable && !reset;
    assign PCWrite    = active && pc_raw;
    assign IFIDWrite  = active && ifid_raw;
    assign IDEXBubble = active && bub_raw;
    assign IFIDFlush  = active && flush_raw;
    assign Halted     = !reset && (state == HALTED);

`ifdef HAZARD_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            StallCycles <= '0;
        else if (i_enable && bub_raw && (state == RUN || state == STALL) && StallCycles != 32'hFFFF_FFFF)
            StallCycles <= StallCycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expected values are hand-derived per vector.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset, i_enable;
    logic [4:0] RegRS_IFID, RegRT_IFID, RegDst_IDEX, RegDst_EXMEM;
    logic       UsesRT_IFID, Branch_IFID, Halt_IFID, Taken_ID;
    logic       MemRead_IDEX, RegWrite_IDEX, MemRead_EXMEM;
    logic       PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Halted;
`ifdef HAZARD_CTRL_STATS_EN
    logic [31:0] StallCycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .i_enable(i_enable),
        .RegRS_IFID(RegRS_IFID), .RegRT_IFID(RegRT_IFID), .UsesRT_IFID(UsesRT_IFID),
        .Branch_IFID(Branch_IFID), .Halt_IFID(Halt_IFID), .Taken_ID(Taken_ID),
        .MemRead_IDEX(MemRead_IDEX), .RegWrite_IDEX(RegWrite_IDEX), .RegDst_IDEX(RegDst_IDEX),
        .MemRead_EXMEM(MemRead_EXMEM), .RegDst_EXMEM(RegDst_EXMEM),
`ifdef HAZARD_CTRL_STATS_EN
        .StallCycles(StallCycles),
`endif
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
        .IFIDFlush(IFIDFlush), .Halted(Halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic pc, input logic ifid, input logic bub,
                        input logic fl, input logic hl);
        chk({tag, ".pc"},     32'(PCWrite),    32'(pc));
        chk({tag, ".ifid"},   32'(IFIDWrite),  32'(ifid));
        chk({tag, ".bub"},    32'(IDEXBubble), 32'(bub));
        chk({tag, ".flush"},  32'(IFIDFlush),  32'(fl));
        chk({tag, ".halted"}, 32'(Halted),     32'(hl));
    endtask

    task automatic clr();
        RegRS_IFID = 5'd0; RegRT_IFID = 5'd0; UsesRT_IFID = 1'b0; Branch_IFID = 1'b0;
        Halt_IFID = 1'b0; Taken_ID = 1'b0; MemRead_IDEX = 1'b0; RegWrite_IDEX = 1'b0;
        RegDst_IDEX = 5'd0; MemRead_EXMEM = 1'b0; RegDst_EXMEM = 5'd0;
    endtask

    // Inputs change just after a falling edge; outputs are checked 1 ns later.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nxt(); reset = 1'b1; clr();
        #1 outs("rst", 0, 0, 0, 0, 0);
        nxt(); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; i_enable = 1'b1; clr();
        nxt(); #1 outs("rst0", 0, 0, 0, 0, 0);
        nxt(); reset = 1'b0;
        #1 outs("idle", 1, 1, 0, 0, 0);

        // load-use, single stall
        nxt(); MemRead_IDEX = 1; RegDst_IDEX = 5'd9; RegRS_IFID = 5'd9;
        #1 outs("lu.s1", 0, 0, 1, 0, 0);
        nxt(); clr();
        #1 outs("lu.go", 1, 1, 0, 0, 0);
        // load to $0 never stalls
        nxt(); MemRead_IDEX = 1; RegDst_IDEX = 5'd0; RegRS_IFID = 5'd0;
        #1 outs("lu.r0", 1, 1, 0, 0, 0);
        // rt match ignored when rt is not a source
        nxt(); clr(); MemRead_IDEX = 1; RegDst_IDEX = 5'd7; RegRT_IFID = 5'd7; RegRS_IFID = 5'd3;
        #1 outs("lu.nort", 1, 1, 0, 0, 0);

        // branch after load: two stalls, then a one-cycle flush
        nxt(); clr(); Branch_IFID = 1; MemRead_IDEX = 1; RegDst_IDEX = 5'd8;
        RegRT_IFID = 5'd8; UsesRT_IFID = 1; RegRS_IFID = 5'd3;
        #1 outs("bl.s1", 0, 0, 1, 0, 0);
        nxt(); MemRead_IDEX = 0; RegDst_IDEX = 5'd0; MemRead_EXMEM = 1; RegDst_EXMEM = 5'd8; Taken_ID = 1;
        #1 outs("bl.s2", 0, 0, 1, 0, 0);
        nxt(); MemRead_EXMEM = 0; RegDst_EXMEM = 5'd0;
        #1 outs("bl.flush", 1, 1, 0, 1, 0);
        nxt(); clr();
        #1 outs("bl.after", 1, 1, 0, 0, 0);

        // branch on ALU result: one stall, flush suppressed while stalled
        nxt(); RegWrite_IDEX = 1; RegDst_IDEX = 5'd12; RegRS_IFID = 5'd12; Branch_IFID = 1; Taken_ID = 1;
        #1 outs("ba.s1", 0, 0, 1, 0, 0);
        nxt(); RegWrite_IDEX = 0; RegDst_IDEX = 5'd0;
        #1 outs("ba.flush", 1, 1, 0, 1, 0);

        // branch on load sitting in MEM
        nxt(); clr(); Branch_IFID = 1; MemRead_EXMEM = 1; RegDst_EXMEM = 5'd5; RegRS_IFID = 5'd5;
        #1 outs("bm.s1", 0, 0, 1, 0, 0);
        nxt(); clr();
        #1 outs("bm.go", 1, 1, 0, 0, 0);

        // enable freeze in the middle of a 2-cycle stall
        do_reset();
        Branch_IFID = 1; MemRead_IDEX = 1; RegDst_IDEX = 5'd8; RegRT_IFID = 5'd8; UsesRT_IFID = 1;
        #1 outs("fz.s1", 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            nxt(); i_enable = 0;
            #1 outs("fz.off", 0, 0, 0, 0, 0);
        end
        nxt(); i_enable = 1;
        #1 outs("fz.s2", 0, 0, 1, 0, 0);
        nxt(); clr();
        #1 outs("fz.go", 1, 1, 0, 0, 0);
`ifdef HAZARD_CTRL_STATS_EN
        chk("fz.stats", StallCycles, 32'd2);
`endif

        // hazard outranks halt; halt is taken on the next hazard-free cycle
        do_reset();
        Halt_IFID = 1; MemRead_IDEX = 1; RegDst_IDEX = 5'd4; RegRS_IFID = 5'd4;
        #1 outs("hp.stall", 0, 0, 1, 0, 0);
        nxt(); MemRead_IDEX = 0; RegDst_IDEX = 5'd0;
        #1 outs("hp.h1", 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            nxt();
            #1 outs("hp.drain", 0, 0, 1, 0, 0);
        end
        nxt();
        #1 outs("hp.halted", 0, 0, 0, 0, 1);

        // plain halt: 4 bubbles, Halted on the 5th cycle, sticky, cleared by reset
        do_reset();
        Halt_IFID = 1;
        for (int i = 0; i < 4; i++) begin
            #1 outs("h.bub", 0, 0, 1, 0, 0);
            nxt();
        end
        #1 outs("h.on", 0, 0, 0, 0, 1);
        Halt_IFID = 0; Taken_ID = 1; MemRead_IDEX = 1; RegDst_IDEX = 5'd2; RegRS_IFID = 5'd2;
        for (int i = 0; i < 20; i++) begin
            nxt();
            #1 outs("h.hold", 0, 0, 0, 0, 1);
        end
        do_reset();
        #1 outs("h.clr", 1, 1, 0, 0, 0);

        // reset in the 2nd drain cycle aborts the drain
        nxt(); Halt_IFID = 1;
        #1 outs("rd.h", 0, 0, 1, 0, 0);
        nxt();
        #1 outs("rd.d1", 0, 0, 1, 0, 0);
        nxt(); reset = 1;
        #1 outs("rd.rst", 0, 0, 0, 0, 0);
        nxt(); reset = 0; Halt_IFID = 0;
        #1 outs("rd.run", 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            #1 outs("rd.stay", 1, 1, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
